funnel_arbiter: RTL and testbench
=================================

# funnel_arbiter

Round-robin arbiter and sequencer that shares one 64→4 funnel (serializer) between N packet-producing requesters. It chooses a source at each funnel word boundary and drives the funnel's enqueue word. It holds the grant for a whole multi-word packet and tags every 4-bit output beat with its source index and a data/fill flag. It sits directly upstream of the funnel. The funnel has no enqueue-valid, so this block is the only thing that decides what the funnel loads.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- IN_W, 64, word width
- OUT_W, 4, funnel beat width; BEATS = IN_W/OUT_W = 16

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester word valid
- req_last  in  N_REQ  word is last of packet
- req_bits  in  N_REQ*IN_W  per-requester word, requester i at [i*IN_W +: IN_W]
- req_ready  out  N_REQ  word accepted this cycle
- fun_enq_ready  in  1  funnel enq_ready (funnel at beat 0 and deq firing)
- fun_deq_ready  in  1  funnel deq_ready (funnel deq_valid is constant 1, so this is the beat fire)
- fun_enq_bits  out  IN_W  word loaded by the funnel
- out_src  out  clog2(N_REQ)  source of the funnel's current output beat
- out_vld  out  1  current beat carries requester data (0 = idle fill)
- sync_err  out  1  sticky: fun_enq_ready disagreed with the internal beat counter

## Operation
- FSM states: IDLE (no grant held) and PKT (grant locked to grant_q).
- Word boundary: cycle with fun_enq_ready=1. The funnel loads fun_enq_bits unconditionally at a boundary.
- IDLE at a boundary:
  - Winner = first asserted req_valid at or after rr_ptr, searching cyclically.
  - fun_enq_bits = winner's word; req_ready[winner]=1.
  - rr_ptr ← winner+1 mod N_REQ.
  - If req_last of winner is 0: go to PKT with grant_q ← winner; otherwise stay in IDLE.
  - If there is no valid requester: fun_enq_bits = 0 and beat tag vld = 0.
- PKT at a boundary:
  - Only grant_q is considered. If req_valid[grant_q]=1: load its word and assert its req_ready. On req_last, go to IDLE.
  - If req_valid[grant_q]=0: load a fill word (0, vld=0) and stay in PKT.
- Outside a boundary: req_ready = 0 and fun_enq_bits = 0 (don't-care to the funnel).
- Requester rule: once req_valid is asserted, req_valid, req_bits and req_last stay stable until req_ready.
- Beat tag:
  - At a boundary: out_src/out_vld are the combinational selection, matching the funnel's bypassed beat 0. tag_q ← selection.
  - Otherwise: out_src/out_vld = tag_q.
- Beat counter beat_q, 4 bits:
  - Increments on fun_deq_ready and wraps 15→0.
  - sync_err sets when fun_enq_ready ≠ (beat_q==0 && fun_deq_ready) and stays set until reset.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_q 0, beat_q 0, tag_q {src 0, vld 0}, sync_err 0.
- Outputs during reset: req_ready 0, out_vld 0, out_src 0, fun_enq_bits 0.
- req_ready, fun_enq_bits, out_src and out_vld are combinational from fun_enq_ready and the request inputs. There is no added latency.
- Per-word throughput: one word every 16 fun_deq_ready cycles. Back-to-back packets from different sources need no bubble.
- Boundary with fun_deq_ready=0: cannot occur. If it does, sync_err sets.
- Reset mid-packet: the packet is dropped and the block returns to IDLE. The funnel must be reset in the same cycle.
- A single-word packet (req_last=1 on the first word) never enters PKT.

## Configuration
- FUNNEL_ARB_STATS_EN defined:
  - Adds output stat_words (N_REQ*32): per-requester 32-bit saturating count of accepted words.
  - Adds output stat_fill (32): count of fill words loaded while in PKT.
  - All counters reset to 0.
- Not defined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package funnel_pkg holds:
  - IN_W, OUT_W, BEATS constants
  - the FSM state enum {IDLE, PKT}
  - the beat tag struct {src, vld}
- Sub-module rr_pick: combinational round-robin picker (valid vector + pointer → onehot, index, any). It is reusable by other funnel users.

## Test plan
- Single source: req_valid=0001, word 0x0123456789ABCDEF with last=1, boundary → req_ready=0001; the next 16 beats are F,E,…,0 with out_src=0, out_vld=1.
- Rotation: all four valid, single-word packets, rr_ptr=0 → grants in order 0,1,2,3,0, one per 16 beats.
- Packet lock: req1 sends a 3-word packet while req2 stays valid → three consecutive req1 words, then req2. rr_ptr=2 after the first word.
- Bubble: in PKT with req_valid[grant_q] dropped → the fill word loads, out_vld=0 for 16 beats, state stays PKT, and the grant resumes when valid returns.
- Idle: no requests → fun_enq_bits=0, out_vld=0, no req_ready. sync_err stays 0 over 64 fun_deq_ready cycles.
- Reset: assert reset_n=0 mid-packet at beat 7 → all outputs at their reset values asynchronously, state IDLE, and beat_q=0 on release.

Source files
------------

// File: rtl/funnel_pkg.sv
`default_nettype none
//==============================================================================
// Package  : funnel_pkg
// Brief    : Shared constants, FSM state and beat-tag types for funnel users.
// Revision : 1.0 - initial release
//==============================================================================
package funnel_pkg;

   localparam int IN_W      = 64;
   localparam int OUT_W     = 4;
   localparam int BEATS     = IN_W / OUT_W;
   localparam int BEAT_W    = $clog2(BEATS);
   // Wide enough for the largest supported requester count (8)
   localparam int SRC_MAX_W = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_t;

   typedef struct packed {
      logic [SRC_MAX_W-1:0] src;
      logic                 vld;
   } beat_tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
//==============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first valid at or after ptr.
// Revision : 1.0 - initial release
//==============================================================================
module rr_pick
   import funnel_pkg::*;
#(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] i_valid,
   input  logic [W-1:0] i_ptr,
   output logic [N-1:0] o_onehot,
   output logic [W-1:0] o_idx,
   output logic         o_any
);

   logic [W-1:0] w_c;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      w_c      = '0;
      for (int i = 0; i < N; i++) begin
         w_c = W'((int'(i_ptr) + i) % N);
         if (!o_any && i_valid[w_c]) begin
            o_any       = 1'b1;
            o_idx       = w_c;
            o_onehot[w_c] = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/funnel_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : funnel_arbiter
// Brief    : Round-robin packet arbiter feeding one 64->4 funnel serializer.
// Options  : FUNNEL_ARB_STATS_EN adds per-requester word and fill counters.
// Revision : 1.0 - initial release
//==============================================================================
module funnel_arbiter
   import funnel_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ-1:0]      req_last,
   input  logic [N_REQ*IN_W-1:0] req_bits,
   output logic [N_REQ-1:0]      req_ready,
   input  logic                  fun_enq_ready,
   input  logic                  fun_deq_ready,
   output logic [IN_W-1:0]       fun_enq_bits,
   output logic [SRC_W-1:0]      out_src,
   output logic                  out_vld,
   output logic                  sync_err
`ifdef FUNNEL_ARB_STATS_EN
   ,
   output logic [N_REQ*32-1:0]   stat_words,
   output logic [31:0]           stat_fill
`endif
);

   state_t            r_state, w_state_nxt;
   logic [SRC_W-1:0]  r_rr_ptr, w_rr_nxt;
   logic [SRC_W-1:0]  r_grant, w_grant_nxt;
   beat_tag_t         r_tag;
   logic [BEAT_W-1:0] r_beat;
   logic              r_sync_err;

   logic [N_REQ-1:0]  w_pick_oh;
   logic [SRC_W-1:0]  w_pick_idx;
   logic              w_pick_any;
   logic [SRC_W-1:0]  w_sel_src;
   logic [N_REQ-1:0]  w_sel_oh;
   logic              w_take;
   logic              w_fill;
   logic              w_bound;
   logic [IN_W-1:0]   w_words [N_REQ];
   logic              w_tag_unused;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
      assign w_words[gi] = req_bits[gi*IN_W +: IN_W];
   end

   rr_pick #(.N(N_REQ), .W(SRC_W)) u_rr_pick (
      .i_valid  (req_valid),
      .i_ptr    (r_rr_ptr),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   // Gated by reset so nothing is offered to the funnel while it is held in reset
   assign w_bound = fun_enq_ready & reset_n;

   always_comb begin
      w_state_nxt = r_state;
      w_rr_nxt    = r_rr_ptr;
      w_grant_nxt = r_grant;
      w_sel_src   = '0;
      w_sel_oh    = '0;
      w_take      = 1'b0;
      w_fill      = 1'b0;
      case (r_state)
         IDLE: begin
            w_sel_src = w_pick_idx;
            w_sel_oh  = w_pick_oh;
            w_take    = w_pick_any;
            if (w_bound && w_pick_any) begin
               w_rr_nxt = (w_pick_idx == SRC_W'(N_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
               if (!req_last[w_pick_idx]) begin
                  w_state_nxt = PKT;
                  w_grant_nxt = w_pick_idx;
               end
            end
         end
         PKT: begin
            w_sel_src = r_grant;
            w_sel_oh  = N_REQ'(1) << r_grant;
            w_take    = req_valid[r_grant];
            if (w_bound) begin
               if (!w_take)
                  w_fill = 1'b1;
               else if (req_last[r_grant])
                  w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign req_ready    = (w_bound && w_take) ? w_sel_oh : '0;
   assign fun_enq_bits = (w_bound && w_take) ? w_words[w_sel_src] : '0;
   assign out_src      = w_bound ? w_sel_src : r_tag.src[SRC_W-1:0];
   assign out_vld      = w_bound ? w_take : r_tag.vld;
   assign sync_err     = r_sync_err;
   assign w_tag_unused = ^r_tag.src;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_rr_ptr   <= '0;
         r_grant    <= '0;
         r_tag      <= '0;
         r_beat     <= '0;
         r_sync_err <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_grant  <= w_grant_nxt;
         if (w_bound)
            r_tag <= '{src: SRC_MAX_W'(w_sel_src), vld: w_take};
         if (fun_deq_ready)
            r_beat <= r_beat + 1'b1;
         if (fun_enq_ready != ((r_beat == '0) && fun_deq_ready))
            r_sync_err <= 1'b1;
      end
   end

`ifdef FUNNEL_ARB_STATS_EN
   logic [31:0] r_stat_fill;

   for (genvar gs = 0; gs < N_REQ; gs++) begin : g_stats
      logic [31:0] r_cnt;
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n)
            r_cnt <= '0;
         else if (req_ready[gs] && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
      end
      assign stat_words[gs*32 +: 32] = r_cnt;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_stat_fill <= '0;
      else if (w_fill && (r_stat_fill != '1))
         r_stat_fill <= r_stat_fill + 1'b1;
   end
   assign stat_fill = r_stat_fill;
`endif

endmodule
`default_nettype wire

// File: tb/tb_funnel_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_funnel_arbiter
// Brief    : Directed scoreboard bench for funnel_arbiter (N_REQ = 4).
// Revision : 1.0 - initial release
//==============================================================================
module tb_funnel_arbiter;
   import funnel_pkg::*;

   logic         clock;
   logic         reset_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_last;
   logic [255:0] req_bits;
   logic [3:0]   req_ready;
   logic         fun_enq_ready;
   logic         fun_deq_ready;
   logic [63:0]  fun_enq_bits;
   logic [1:0]   out_src;
   logic         out_vld;
   logic         sync_err;
`ifdef FUNNEL_ARB_STATS_EN
   logic [127:0] stat_words;
   logic [31:0]  stat_fill;
`endif

   funnel_arbiter #(.N_REQ(4)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_last      (req_last),
      .req_bits      (req_bits),
      .req_ready     (req_ready),
      .fun_enq_ready (fun_enq_ready),
      .fun_deq_ready (fun_deq_ready),
      .fun_enq_bits  (fun_enq_bits),
      .out_src       (out_src),
      .out_vld       (out_vld),
      .sync_err      (sync_err)
`ifdef FUNNEL_ARB_STATS_EN
      ,
      .stat_words    (stat_words),
      .stat_fill     (stat_fill)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [1:0]  src;
      logic        vld;
      logic [63:0] word;
   } exp_t;

   int          checks   = 0;
   int          failures = 0;
   exp_t        sb[$];
   exp_t        cur;
   logic [63:0] rq_word [4][$];
   logic        rq_last [4][$];
   bit          hold    [4];
   logic [3:0]  tb_beat;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_req(input int i, input logic [63:0] w, input logic l);
      rq_word[i].push_back(w);
      rq_last[i].push_back(l);
   endtask

   task automatic push_exp(input logic [1:0] s, input logic v, input logic [63:0] w);
      exp_t e;
      e.src  = s;
      e.vld  = v;
      e.word = w;
      sb.push_back(e);
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < 4; i++) begin
         if (rq_word[i].size() > 0 && !hold[i]) begin
            req_valid[i]          = 1'b1;
            req_last[i]           = rq_last[i][0];
            req_bits[i*64 +: 64]  = rq_word[i][0];
         end else begin
            req_valid[i]          = 1'b0;
            req_last[i]           = 1'b0;
            req_bits[i*64 +: 64]  = '0;
         end
      end
   endtask

   // Starts and ends at posedge+1; funnel is modelled as always draining
   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         drive_reqs();
         fun_deq_ready = 1'b1;
         fun_enq_ready = (tb_beat == 4'd0);
         #1;
         if (fun_enq_ready) begin
            if (sb.size() == 0) begin
               check("sb_empty_at_boundary", 64'(sb.size()), 64'd1);
               cur = '0;
            end else begin
               cur = sb.pop_front();
            end
            check("rdy", 64'(req_ready), cur.vld ? 64'(4'b0001 << cur.src) : 64'd0);
            check("bits", fun_enq_bits, cur.vld ? cur.word : 64'd0);
            check("vld", 64'(out_vld), 64'(cur.vld));
            if (cur.vld) check("src", 64'(out_src), 64'(cur.src));
         end else begin
            check("rdy_mid", 64'(req_ready), 64'd0);
            check("bits_mid", fun_enq_bits, 64'd0);
            check("vld_mid", 64'(out_vld), 64'(cur.vld));
            if (cur.vld) check("src_mid", 64'(out_src), 64'(cur.src));
         end
         @(posedge clock);
         #1;
         if (fun_enq_ready && cur.vld) begin
            void'(rq_word[cur.src].pop_front());
            void'(rq_last[cur.src].pop_front());
         end
         tb_beat = tb_beat + 4'd1;
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      req_valid     = 4'hF;
      req_last      = 4'hF;
      req_bits      = {4{64'hDEAD_BEEF_CAFE_F00D}};
      fun_enq_ready = 1'b1;
      fun_deq_ready = 1'b1;
      tb_beat       = 4'd0;
      cur           = '0;
      for (int i = 0; i < 4; i++) hold[i] = 1'b0;

      // Reset: outputs held at zero even with a boundary and requests present
      repeat (2) @(posedge clock);
      #1;
      check("rst_rdy", 64'(req_ready), 64'd0);
      check("rst_bits", fun_enq_bits, 64'd0);
      check("rst_src", 64'(out_src), 64'd0);
      check("rst_vld", 64'(out_vld), 64'd0);
      check("rst_sync_err", 64'(sync_err), 64'd0);
      reset_n       = 1'b1;
      fun_enq_ready = 1'b0;

      // Rotation: all four valid, single-word packets, grants 0,1,2,3,0
      push_req(0, 64'hA000_0000_0000_0000, 1'b1);
      push_req(0, 64'hA000_0000_0000_0004, 1'b1);
      push_req(1, 64'hA000_0000_0000_0001, 1'b1);
      push_req(2, 64'hA000_0000_0000_0002, 1'b1);
      push_req(3, 64'hA000_0000_0000_0003, 1'b1);
      push_exp(0, 1'b1, 64'hA000_0000_0000_0000);
      push_exp(1, 1'b1, 64'hA000_0000_0000_0001);
      push_exp(2, 1'b1, 64'hA000_0000_0000_0002);
      push_exp(3, 1'b1, 64'hA000_0000_0000_0003);
      push_exp(0, 1'b1, 64'hA000_0000_0000_0004);
      run_cycles(5 * 16);

      // Single source
      push_req(0, 64'h0123_4567_89AB_CDEF, 1'b1);
      push_exp(0, 1'b1, 64'h0123_4567_89AB_CDEF);
      run_cycles(16);

      // Packet lock: req1 three words while req2 waits
      push_req(1, 64'hB100_0000_0000_0001, 1'b0);
      push_req(1, 64'hB100_0000_0000_0002, 1'b0);
      push_req(1, 64'hB100_0000_0000_0003, 1'b1);
      push_req(2, 64'hB200_0000_0000_0001, 1'b1);
      push_exp(1, 1'b1, 64'hB100_0000_0000_0001);
      push_exp(1, 1'b1, 64'hB100_0000_0000_0002);
      push_exp(1, 1'b1, 64'hB100_0000_0000_0003);
      push_exp(2, 1'b1, 64'hB200_0000_0000_0001);
      run_cycles(1);
      check("rr_after_lock", 64'(dut.r_rr_ptr), 64'd2);
      run_cycles(15 + 3 * 16);

      // Bubble: req3 stalls mid-packet, req0 must not steal the slot
      push_req(3, 64'hC300_0000_0000_0001, 1'b0);
      push_req(3, 64'hC300_0000_0000_0002, 1'b1);
      push_req(0, 64'hC000_0000_0000_0001, 1'b1);
      push_exp(3, 1'b1, 64'hC300_0000_0000_0001);
      push_exp(3, 1'b0, 64'd0);
      push_exp(3, 1'b1, 64'hC300_0000_0000_0002);
      push_exp(0, 1'b1, 64'hC000_0000_0000_0001);
      run_cycles(16);
      hold[3] = 1'b1;
      run_cycles(16);
      check("state_bubble", 64'(dut.r_state), 64'(PKT));
      hold[3] = 1'b0;
      run_cycles(2 * 16);

      // Idle: 64 beats with no requests
      for (int i = 0; i < 4; i++) push_exp(0, 1'b0, 64'd0);
      run_cycles(4 * 16);
      check("idle_sync_err", 64'(sync_err), 64'd0);

      // Reset in the middle of a packet, at beat 7 of its second word
      push_req(1, 64'hD100_0000_0000_0001, 1'b0);
      push_req(1, 64'hD100_0000_0000_0002, 1'b0);
      push_req(1, 64'hD100_0000_0000_0003, 1'b1);
      push_exp(1, 1'b1, 64'hD100_0000_0000_0001);
      push_exp(1, 1'b1, 64'hD100_0000_0000_0002);
      run_cycles(16 + 7);
      check("state_pre_rst", 64'(dut.r_state), 64'(PKT));
      reset_n = 1'b0;
      fun_enq_ready = 1'b1;
      drive_reqs();
      #1;
      check("mid_rst_rdy", 64'(req_ready), 64'd0);
      check("mid_rst_bits", fun_enq_bits, 64'd0);
      check("mid_rst_src", 64'(out_src), 64'd0);
      check("mid_rst_vld", 64'(out_vld), 64'd0);
      check("mid_rst_state", 64'(dut.r_state), 64'(IDLE));
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
         rq_word[i].delete();
         rq_last[i].delete();
      end
      sb.delete();
      cur           = '0;
      reset_n       = 1'b1;
      fun_enq_ready = 1'b0;
      tb_beat       = 4'd0;
      check("beat_after_rst", 64'(dut.r_beat), 64'd0);

      // Pointer restarts at 0: req0 before req3
      push_req(0, 64'hE000_0000_0000_0001, 1'b1);
      push_req(3, 64'hE300_0000_0000_0001, 1'b1);
      push_exp(0, 1'b1, 64'hE000_0000_0000_0001);
      push_exp(3, 1'b1, 64'hE300_0000_0000_0001);
      run_cycles(2 * 16);
      check("sb_drained", 64'(sb.size()), 64'd0);
      check("sync_err_clean", 64'(sync_err), 64'd0);

      // Missing boundary at beat 0 must latch sync_err
      drive_reqs();
      fun_deq_ready = 1'b1;
      fun_enq_ready = 1'b0;
      @(posedge clock);
      #1;
      check("sync_err_set", 64'(sync_err), 64'd1);
      repeat (3) @(posedge clock);
      #1;
      check("sync_err_sticky", 64'(sync_err), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
